// File: rtl/loop_ddr4_tester.sv
// loop_ddr4_tester: DDR4 UI-domain pattern tester.
// Host register writes configure a write-then-readback pattern run on the MIG app interface;
// progress, counters and pass/fail come back as four packed 32-bit read registers.
// MIG handshakes: a command beat is taken on a rising edge where app_en && app_rdy, and a write beat
// additionally needs app_wdf_rdy in that same cycle. Until the beat is taken, command, address and
// data stay unchanged. Read data is taken whenever app_rd_data_valid is high, with no back-pressure.
module loop_ddr4_tester #(
  parameter int REG_ADDR_W       = 12,
  parameter int DDR4_NUM_RD_REGS = 4,
  parameter int APP_ADDR_W       = 31,
  parameter int APP_DATA_W       = 512,
  parameter int ADDR_STEP        = 8
) (
  input  logic                          ddr4_ui_clk,
  input  logic                          ddr4_ui_rst,
  input  logic                          ddr4_reg_rst,
  input  logic                          ddr4_reg_we,
  input  logic [REG_ADDR_W-1:0]         ddr4_reg_addr,
  input  logic [31:0]                   ddr4_reg_wdata,
  output logic [DDR4_NUM_RD_REGS*32-1:0] ddr4_reg_rdata,
  input  logic                          init_calib_complete,
  output logic                          app_en,
  output logic [2:0]                    app_cmd,
  output logic [APP_ADDR_W-1:0]         app_addr,
  input  logic                          app_rdy,
  output logic [APP_DATA_W-1:0]         app_wdf_data,
  output logic                          app_wdf_wren,
  output logic                          app_wdf_end,
  output logic [APP_DATA_W/8-1:0]       app_wdf_mask,
  input  logic                          app_wdf_rdy,
  input  logic [APP_DATA_W-1:0]         app_rd_data,
  input  logic                          app_rd_data_valid
);

  localparam int NUM_LANES = APP_DATA_W / 32;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_READ  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [REG_ADDR_W-1:0] ADDR_CTRL = REG_ADDR_W'(12'h004);
  localparam logic [REG_ADDR_W-1:0] ADDR_NUM  = REG_ADDR_W'(12'h008);
  localparam logic [REG_ADDR_W-1:0] ADDR_SEED = REG_ADDR_W'(12'h00C);
  localparam logic [REG_ADDR_W-1:0] ADDR_BASE = REG_ADDR_W'(12'h010);

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  // Configuration (cleared by hard reset only)
  logic [31:0]           num_words_q, num_words_d;
  logic [31:0]           seed_q, seed_d;
  logic [APP_ADDR_W-1:0] base_addr_q, base_addr_d;

  // Run state (cleared by either reset)
  logic [1:0]            state_q, state_d;
  logic [31:0]           wr_cnt_q, wr_cnt_d;
  logic [31:0]           rd_iss_q, rd_iss_d;
  logic [31:0]           rd_cnt_q, rd_cnt_d;
  logic [31:0]           err_cnt_q, err_cnt_d;
  logic                  app_en_q, app_en_d;
  logic [2:0]            app_cmd_q, app_cmd_d;
  logic [APP_ADDR_W-1:0] app_addr_q, app_addr_d;
  logic [APP_DATA_W-1:0] app_wdf_data_q, app_wdf_data_d;
  logic                  app_wren_q, app_wren_d;
  logic [127:0]          rdata_q, rdata_d;

  logic                  any_rst;
  logic                  start_strobe;
  logic                  start_ok;
  logic [31:0]           wr_cnt_next;
  logic [31:0]           wr_word_next;
  logic [31:0]           rd_iss_next;
  logic [31:0]           rd_cnt_next;
  logic [31:0]           exp_word;
  logic [APP_DATA_W-1:0] exp_data;
  logic [31:0]           status;
  logic                  unused_wdata;

  assign any_rst      = ddr4_ui_rst | ddr4_reg_rst;
  assign start_strobe = ddr4_reg_we && (ddr4_reg_addr == ADDR_CTRL) && ddr4_reg_wdata[0];
  assign start_ok     = start_strobe && init_calib_complete &&
                        ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign wr_cnt_next  = wr_cnt_q + 32'd1;
  assign wr_word_next = seed_q + wr_cnt_next;
  assign rd_iss_next  = rd_iss_q + 32'd1;
  assign rd_cnt_next  = rd_cnt_q + 32'd1;
  assign exp_word     = seed_q + rd_cnt_q;
  assign exp_data     = {NUM_LANES{exp_word}};
  assign unused_wdata = ^ddr4_reg_wdata[31:APP_ADDR_W];

  // Config register decode from the host write strobe
  always_comb begin
    num_words_d = num_words_q;
    seed_d      = seed_q;
    base_addr_d = base_addr_q;
    if (ddr4_reg_we) begin
      if (ddr4_reg_addr == ADDR_NUM)  num_words_d = ddr4_reg_wdata;
      if (ddr4_reg_addr == ADDR_SEED) seed_d      = ddr4_reg_wdata;
      if (ddr4_reg_addr == ADDR_BASE) base_addr_d = ddr4_reg_wdata[APP_ADDR_W-1:0];
    end
  end

  // Pattern FSM: write NUM_WORDS beats, issue NUM_WORDS reads, check returned data in order
  always_comb begin
    state_d        = state_q;
    wr_cnt_d       = wr_cnt_q;
    rd_iss_d       = rd_iss_q;
    rd_cnt_d       = rd_cnt_q;
    err_cnt_d      = err_cnt_q;
    app_en_d       = app_en_q;
    app_cmd_d      = app_cmd_q;
    app_addr_d     = app_addr_q;
    app_wdf_data_d = app_wdf_data_q;
    app_wren_d     = app_wren_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_ok) begin
          wr_cnt_d  = '0;
          rd_iss_d  = '0;
          rd_cnt_d  = '0;
          err_cnt_d = '0;
          if (num_words_q == 32'd0) begin
            state_d  = ST_DONE;
            app_en_d = 1'b0;
          end else begin
            // First write beat is presented in the cycle right after the strobe
            state_d        = ST_WRITE;
            app_en_d       = 1'b1;
            app_cmd_d      = CMD_WRITE;
            app_wren_d     = 1'b1;
            app_addr_d     = base_addr_q;
            app_wdf_data_d = {NUM_LANES{seed_q}};
          end
        end
      end
      ST_WRITE: begin
        if (app_rdy && app_wdf_rdy) begin
          wr_cnt_d = wr_cnt_next;
          if (wr_cnt_next == num_words_q) begin
            state_d    = ST_READ;
            app_en_d   = 1'b1;
            app_cmd_d  = CMD_READ;
            app_wren_d = 1'b0;
            app_addr_d = base_addr_q;
          end else begin
            app_addr_d     = app_addr_q + APP_ADDR_W'(ADDR_STEP);
            app_wdf_data_d = {NUM_LANES{wr_word_next}};
          end
        end
      end
      ST_READ: begin
        if (app_en_q && app_rdy) begin
          rd_iss_d = rd_iss_next;
          if (rd_iss_next == num_words_q) app_en_d = 1'b0;
          else app_addr_d = app_addr_q + APP_ADDR_W'(ADDR_STEP);
        end
        if (app_rd_data_valid) begin
          rd_cnt_d = rd_cnt_next;
          if ((app_rd_data != exp_data) && (err_cnt_q != 32'hFFFF_FFFF))
            err_cnt_d = err_cnt_q + 32'd1;
          if (rd_cnt_next == num_words_q) begin
            state_d  = ST_DONE;
            app_en_d = 1'b0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Host-visible registers, built from current state and sampled one cycle later
  always_comb begin
    status      = '0;
    status[0]   = (state_q == ST_WRITE) || (state_q == ST_READ);
    status[1]   = (state_q == ST_DONE);
    status[2]   = (state_q == ST_DONE) && (err_cnt_q == 32'd0);
    status[3]   = init_calib_complete;
    status[5:4] = state_q;
    rdata_d     = {err_cnt_q, rd_cnt_q, wr_cnt_q, status};
  end

  // Config flops: only the hard reset clears them
  always_ff @(posedge ddr4_ui_clk) begin
    if (ddr4_ui_rst) begin
      num_words_q <= '0;
      seed_q      <= '0;
      base_addr_q <= '0;
    end else begin
      num_words_q <= num_words_d;
      seed_q      <= seed_d;
      base_addr_q <= base_addr_d;
    end
  end

  // Run-state flops: hard or soft reset aborts any run in progress
  always_ff @(posedge ddr4_ui_clk) begin
    if (any_rst) begin
      state_q        <= ST_IDLE;
      wr_cnt_q       <= '0;
      rd_iss_q       <= '0;
      rd_cnt_q       <= '0;
      err_cnt_q      <= '0;
      app_en_q       <= 1'b0;
      app_cmd_q      <= '0;
      app_addr_q     <= '0;
      app_wdf_data_q <= '0;
      app_wren_q     <= 1'b0;
      rdata_q        <= '0;
    end else begin
      state_q        <= state_d;
      wr_cnt_q       <= wr_cnt_d;
      rd_iss_q       <= rd_iss_d;
      rd_cnt_q       <= rd_cnt_d;
      err_cnt_q      <= err_cnt_d;
      app_en_q       <= app_en_d;
      app_cmd_q      <= app_cmd_d;
      app_addr_q     <= app_addr_d;
      app_wdf_data_q <= app_wdf_data_d;
      app_wren_q     <= app_wren_d;
      rdata_q        <= rdata_d;
    end
  end

  assign app_en         = app_en_q;
  assign app_cmd        = app_cmd_q;
  assign app_addr       = app_addr_q;
  assign app_wdf_data   = app_wdf_data_q;
  assign app_wdf_wren   = app_wren_q;
  assign app_wdf_end    = app_wren_q;
  assign app_wdf_mask   = '0;
  assign ddr4_reg_rdata = rdata_q;

endmodule
